// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the pc_ctrl program-counter sequencer:
// FSM state encoding, jump-table geometry and the saturating counter helper.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pcState_t;

  localparam int LUT_DEPTH  = 16;
  localparam int LUT_AW     = $clog2(LUT_DEPTH);
  localparam int INST_CNT_W = 16;

  function automatic logic [INST_CNT_W-1:0] sat_inc(input logic [INST_CNT_W-1:0] v);
    return (v == {INST_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// Bus between the decode/execute stages and pc_ctrl: control inputs,
// jump-table write port, and the PC/status outputs.
interface pc_ctrl_if #(
  parameter int PC_W = 10
);

  logic                            start;
  logic                            stall;
  logic                            jumpFlag;
  logic [7:0]                      jumpField;
  logic                            haltReq;
  logic                            lutWe;
  logic [pc_ctrl_pkg::LUT_AW-1:0]  lutAddr;
  logic [PC_W-1:0]                 lutData;
  logic [PC_W-1:0]                 pc;
  logic                            fetchValid;
  logic                            done;
  logic [pc_ctrl_pkg::INST_CNT_W-1:0] instCount;

  modport master (
    output start, stall, jumpFlag, jumpField, haltReq, lutWe, lutAddr, lutData,
    input  pc, fetchValid, done, instCount
  );

  modport slave (
    input  start, stall, jumpFlag, jumpField, haltReq, lutWe, lutAddr, lutData,
    output pc, fetchValid, done, instCount
  );

endinterface

// File: rtl/pc_ctrl_jump_lut.sv
// 16-entry jump-target table: combinational read, synchronous write,
// asynchronous clear on reset.
module jump_lut
  import pc_ctrl_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [LUT_AW-1:0] waddr,
  input  logic [PC_W-1:0]   wdata,
  input  logic [LUT_AW-1:0] raddr,
  output logic [PC_W-1:0]   rdata
);

  logic [PC_W-1:0] entry_q [LUT_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else if (we) begin
      entry_q[waddr] <= wdata;
    end
  end

  // Read sees the pre-write contents, so a same-cycle jump gets the old entry.
  assign rdata = entry_q[raddr];

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter sequencer (IDLE/RUN/DONE). Define JUMP_LUT_EN to take jump
// targets from a 16-entry table; otherwise jumps are PC-relative.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic     clk,
  input  logic     reset,
  pc_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]            state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [INST_CNT_W-1:0] inst_count_q, inst_count_d;
  logic [PC_W-1:0]       jump_target;

`ifdef JUMP_LUT_EN
  logic unused_jump_hi;
  assign unused_jump_hi = ^bus.jumpField[7:4];

  jump_lut #(
    .PC_W (PC_W)
  ) u_jump_lut (
    .clk   (clk),
    .reset (reset),
    .we    (bus.lutWe),
    .waddr (bus.lutAddr),
    .wdata (bus.lutData),
    .raddr (bus.jumpField[LUT_AW-1:0]),
    .rdata (jump_target)
  );
`else
  logic unused_lut;
  assign unused_lut = ^{bus.lutWe, bus.lutAddr, bus.lutData};

  assign jump_target = pc_q + PC_W'($signed(bus.jumpField));
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_count_d = inst_count_q;
    case (state_q)
      ST_RUN: begin
        if (!bus.stall) begin
          inst_count_d = sat_inc(inst_count_q);
          if (bus.haltReq) begin
            state_d = ST_DONE;
          end else if (bus.jumpFlag) begin
            pc_d = jump_target;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d      = ST_RUN;
          pc_d         = START_ADDR;
          inst_count_d = '0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        pc_d         = START_ADDR;
        inst_count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= START_ADDR;
      inst_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_count_q <= inst_count_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.instCount = inst_count_q;
  // fetchValid must reflect this cycle's stall, so it is gated by the input directly.
  assign bus.fetchValid = (state_q == ST_RUN) && !bus.stall;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed table, hand-written corner
// sequences and randomized stimulus against a behavioural model.
module tb_pc_ctrl;

  localparam int PC_W   = 10;
  localparam int PC_MOD = 1 << PC_W;

  logic clk;
  logic reset;

  pc_ctrl_if #(.PC_W(PC_W)) bus ();

  pc_ctrl #(
    .PC_W       (PC_W),
    .START_ADDR ('0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks_total++;
    if (act == exp) checks_passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
  int m_mode, m_pc, m_cnt;
  int m_tbl [16];

  task automatic model_reset();
    m_mode = M_IDLE;
    m_pc   = 0;
    m_cnt  = 0;
    for (int i = 0; i < 16; i++) m_tbl[i] = 0;
  endtask

  task automatic model_step(input bit st, input bit sl, input bit jf, input int fld,
                            input bit hq, input bit we, input int a, input int d);
    int tgt;
`ifdef JUMP_LUT_EN
    tgt = m_tbl[fld % 16];
`else
    tgt = (m_pc + ((fld >= 128) ? fld - 256 : fld) + PC_MOD) % PC_MOD;
`endif
    if (m_mode == M_RUN) begin
      if (!sl) begin
        m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        if (hq)      m_mode = M_DONE;
        else if (jf) m_pc = tgt;
        else         m_pc = (m_pc + 1) % PC_MOD;
      end
    end else if (st) begin
      m_mode = M_RUN;
      m_pc   = 0;
      m_cnt  = 0;
    end
    if (we) m_tbl[a] = d;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input bit st, input bit sl, input bit jf, input logic [7:0] fld,
                        input bit hq, input bit we, input logic [3:0] a, input logic [9:0] d);
    bus.start     = st;
    bus.stall     = sl;
    bus.jumpFlag  = jf;
    bus.jumpField = fld;
    bus.haltReq   = hq;
    bus.lutWe     = we;
    bus.lutAddr   = a;
    bus.lutData   = d;
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 8'h00, 0, 0, 4'h0, 10'h000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit       start, stall, jf;
    bit [7:0] fld;
    bit       halt;
    bit       exp_fv;
    int       exp_pc;
    bit       exp_done;
    int       exp_cnt;
  } vec_t;

  function automatic vec_t mk(bit st, bit sl, bit jf, bit [7:0] fld, bit hq,
                              bit fv, int pc, bit dn, int cnt);
    vec_t v;
    v.start = st; v.stall = sl; v.jf = jf; v.fld = fld; v.halt = hq;
    v.exp_fv = fv; v.exp_pc = pc; v.exp_done = dn; v.exp_cnt = cnt;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    reset = 1'b1;
    idle_in();
    model_reset();
    tick();
    tick();
    check("rst_pc", int'(bus.pc), 0);
    check("rst_fv", int'(bus.fetchValid), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_cnt", int'(bus.instCount), 0);
    reset = 1'b0;
    tick();
    check("idle_pc", int'(bus.pc), 0);
    check("idle_fv", int'(bus.fetchValid), 0);

`ifndef JUMP_LUT_EN
    // start, 5 plain cycles, negative offsets, wrap, stall, halt, DONE, restart
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 0,     0, 0));
    for (int i = 1; i <= 5; i++) vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1, i, 0, i));
    vecs.push_back(mk(0, 0, 1, 8'hFD, 0, 1, 2,     0, 6));
    vecs.push_back(mk(0, 0, 1, 8'hFC, 0, 1, 10'h3FE, 0, 7));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1, 10'h3FF, 0, 8));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0,     0, 9));
    vecs.push_back(mk(0, 1, 1, 8'h10, 0, 0, 0,     0, 9));
    vecs.push_back(mk(0, 0, 1, 8'h10, 1, 1, 0,     1, 10));
    vecs.push_back(mk(0, 0, 1, 8'h10, 1, 0, 0,     1, 10));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 0, 0,     0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 1, 1,     0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 1, 0, 1,     0, 1));
    vecs.push_back(mk(0, 0, 1, 8'h7F, 0, 1, 128,   0, 2));
    foreach (vecs[i]) begin
      set_in(vecs[i].start, vecs[i].stall, vecs[i].jf, vecs[i].fld, vecs[i].halt, 0, 4'h0, 10'h000);
      #3;
      check($sformatf("vec%0d_fv", i), int'(bus.fetchValid), int'(vecs[i].exp_fv));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_pc", i), int'(bus.pc), vecs[i].exp_pc);
      check($sformatf("vec%0d_done", i), int'(bus.done), int'(vecs[i].exp_done));
      check($sformatf("vec%0d_cnt", i), int'(bus.instCount), vecs[i].exp_cnt);
    end
`else
    // table jumps, read-before-write on the same entry, writes accepted in IDLE
    set_in(0, 0, 0, 8'h00, 0, 1, 4'h5, 10'h2AA);
    tick();
    set_in(1, 0, 0, 8'h00, 0, 1, 4'h3, 10'h120);
    tick();
    check("lut_start_pc", int'(bus.pc), 0);
    set_in(0, 0, 1, 8'h03, 0, 0, 4'h0, 10'h000);
    tick();
    check("lut_jump3", int'(bus.pc), 10'h120);
    set_in(0, 0, 1, 8'h03, 0, 1, 4'h3, 10'h050);
    tick();
    check("lut_rbw_old", int'(bus.pc), 10'h120);
    set_in(0, 0, 1, 8'h03, 0, 0, 4'h0, 10'h000);
    tick();
    check("lut_rbw_new", int'(bus.pc), 10'h050);
    set_in(0, 0, 1, 8'hF5, 0, 0, 4'h0, 10'h000);
    tick();
    check("lut_hi_ignored", int'(bus.pc), 10'h2AA);
    check("lut_cnt", int'(bus.instCount), 4);
`endif

    // stall at pc=7 with pending jump+halt, then halt
    do_reset();
    set_in(1, 0, 0, 8'h00, 0, 0, 4'h0, 10'h000);
    tick();
    idle_in();
    for (int i = 0; i < 7; i++) tick();
    check("s7_pc", int'(bus.pc), 7);
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1, 1, 8'h02, 1, 0, 4'h0, 10'h000);
      #3;
      check($sformatf("s7_stall%0d_fv", i), int'(bus.fetchValid), 0);
      tick();
      check($sformatf("s7_stall%0d_pc", i), int'(bus.pc), 7);
    end
    set_in(0, 0, 1, 8'h02, 1, 0, 4'h0, 10'h000);
    tick();
    idle_in();
    check("s7_done", int'(bus.done), 1);
    check("s7_done_pc", int'(bus.pc), 7);
    check("s7_done_cnt", int'(bus.instCount), 8);
    check("s7_done_fv", int'(bus.fetchValid), 0);

    // asynchronous reset mid-RUN with a pending jump and table write
    do_reset();
`ifdef JUMP_LUT_EN
    set_in(0, 0, 0, 8'h00, 0, 1, 4'h3, 10'h155);
    tick();
`endif
    set_in(1, 0, 0, 8'h00, 0, 0, 4'h0, 10'h000);
    tick();
    idle_in();
    for (int i = 0; i < 'h44; i++) tick();
    check("ar_pre_pc", int'(bus.pc), 'h44);
    set_in(0, 0, 1, 8'h03, 1, 1, 4'h3, 10'h0AA);
    #2;
    reset = 1'b1;
    #1;
    check("ar_pc", int'(bus.pc), 0);
    check("ar_cnt", int'(bus.instCount), 0);
    check("ar_done", int'(bus.done), 0);
    check("ar_fv", int'(bus.fetchValid), 0);
    tick();
    idle_in();
    reset = 1'b0;
    model_reset();
    set_in(1, 0, 0, 8'h00, 0, 0, 4'h0, 10'h000);
    tick();
    set_in(0, 0, 1, 8'h03, 0, 0, 4'h0, 10'h000);
    tick();
    idle_in();
`ifdef JUMP_LUT_EN
    check("ar_tbl_cleared", int'(bus.pc), 0);
`else
    check("ar_rel_jump", int'(bus.pc), 3);
`endif
    check("ar_cnt_after", int'(bus.instCount), 1);

    // randomized run against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bit st, sl, jf, hq, we;
      int fld, a, d;
      st  = ($urandom_range(0, 9) == 0);
      sl  = ($urandom_range(0, 3) == 0);
      jf  = ($urandom_range(0, 2) == 0);
      hq  = ($urandom_range(0, 24) == 0);
      we  = ($urandom_range(0, 2) == 0);
      fld = $urandom_range(0, 255);
      a   = $urandom_range(0, 15);
      d   = $urandom_range(0, PC_MOD - 1);
      set_in(st, sl, jf, 8'(fld), hq, we, 4'(a), 10'(d));
      #3;
      check("rnd_fv", int'(bus.fetchValid), int'((m_mode == M_RUN) && !sl));
      @(posedge clk);
      model_step(st, sl, jf, fld, hq, we, a, d);
      #1;
      check("rnd_pc", int'(bus.pc), m_pc);
      check("rnd_done", int'(bus.done), int'(m_mode == M_DONE));
      check("rnd_cnt", int'(bus.instCount), m_cnt);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
